// File: rtl/mram_serial_host.sv
// ---------------------------------------------------------------------------
// mram_serial_host
//
// Host-side initiator for the serial MRAM bridge. One parallel command
// (address, write data, byte select, read/write) is accepted per valid/ready
// handshake and turned into a serial frame: read_write_sel is held for the
// whole frame while the address and write data are shifted out MSB first.
// For reads, the data the bridge returns serially on rdata_sdi is collected
// and presented as a parallel response word with a one-cycle rsp_valid.
//
// Ports:
//   clk             in   1       system clock, rising edge
//   rst             in   1       synchronous, active-high reset
//   cmd_valid       in   1       command present
//   cmd_ready       out  1       command accepted when cmd_valid & cmd_ready
//   cmd_write       in   1       1 = write, 0 = read
//   cmd_bytes       in   2       [0] lower byte, [1] upper byte; 00 = nop
//   cmd_addr        in   ADDR_W  target address
//   cmd_wdata       in   DATA_W  write data (ignored for reads)
//   read_write_sel  out  3       {bytes[1], bytes[0], write} to the bridge
//   addr_sdo        out  1       serial address bit, MSB first
//   data_sdo        out  1       serial write-data bit, MSB first
//   rdata_sdi       in   1       serial read data from the bridge, MSB first
//   rsp_valid       out  1       one-cycle pulse, rsp_data valid
//   rsp_data        out  DATA_W  captured read word
//   busy            out  1       high in any state other than IDLE
//
// Build option:
//   MRAM_HOST_B2B_EN  when defined, a new command may be accepted on the last
//                     cycle of a write frame so the next frame follows with
//                     no IDLE gap.
// ---------------------------------------------------------------------------
module mram_serial_host #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 23,
    parameter int RESP_DLY  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_bytes,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [2:0]        read_write_sel,
    output logic              addr_sdo,
    output logic              data_sdo,
    input  logic              rdata_sdi,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    localparam int HALF = DATA_W / 2;
    localparam int FCW  = $clog2(FRAME_LEN);
    localparam int DCW  = $clog2(RESP_DLY + DATA_W + 1);

    localparam logic [FCW-1:0] FC_ADDR_LAST = FCW'(ADDR_W - 1);
    localparam logic [FCW-1:0] FC_DATA_LAST = FCW'(DATA_W - 1);
    localparam logic [FCW-1:0] FC_LAST      = FCW'(FRAME_LEN - 1);
`ifdef MRAM_HOST_B2B_EN
    localparam logic [FCW-1:0] FC_PRE_LAST  = FCW'(FRAME_LEN - 2);
`endif

    localparam logic [DCW-1:0] DC_FIRST     = DCW'(RESP_DLY);
    localparam logic [DCW-1:0] DC_LAST_FULL = DCW'(RESP_DLY + DATA_W - 1);
    localparam logic [DCW-1:0] DC_LAST_HALF = DCW'(RESP_DLY + HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT,
        DRAIN
    } state_t;

    state_t            state_q;
    logic [FCW-1:0]    fc_q;
    logic [DCW-1:0]    dc_q;
    logic              write_q;
    logic [1:0]        bytes_q;
    logic [ADDR_W-2:0] addrSh_q;
    logic [DATA_W-2:0] dataSh_q;
    logic [DATA_W-2:0] rxSh_q;

    logic              cmd_ready_q;
    logic [2:0]        rws_q;
    logic              addr_sdo_q;
    logic              data_sdo_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic              handshake;
    logic [DCW-1:0]    dcLast;
    logic [DATA_W-1:0] rxWord;
    logic [DATA_W-1:0] rspWord_d;

    // The response word includes the bit being sampled this cycle, so the
    // final sample and the response update land on the same edge. A half-word
    // read only uses the last HALF samples, placed by the byte select.
    always_comb begin
        handshake = cmd_valid & cmd_ready_q;
        dcLast    = (bytes_q == 2'b11) ? DC_LAST_FULL : DC_LAST_HALF;
        rxWord    = {rxSh_q, rdata_sdi};
        rspWord_d = '0;
        case (bytes_q)
            2'b11:   rspWord_d = rxWord;
            2'b10:   rspWord_d = {rxWord[HALF-1:0], {HALF{1'b0}}};
            default: rspWord_d = {{HALF{1'b0}}, rxWord[HALF-1:0]};
        endcase
    end

    // Main FSM. Every output is a flop loaded with the value it must show in
    // the following cycle, so the first address/data bit is loaded at the
    // handshake and each later bit comes from the top of a shift register.
    // cmd_ready is only ever high where a new command may legally start, so
    // the command load at the bottom can override whatever the state branch
    // chose for the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fc_q        <= '0;
            dc_q        <= '0;
            write_q     <= 1'b0;
            bytes_q     <= 2'b00;
            addrSh_q    <= '0;
            dataSh_q    <= '0;
            rxSh_q      <= '0;
            cmd_ready_q <= 1'b0;
            rws_q       <= 3'b000;
            addr_sdo_q  <= 1'b0;
            data_sdo_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    rws_q       <= 3'b000;
                    addr_sdo_q  <= 1'b0;
                    data_sdo_q  <= 1'b0;
                end

                SHIFT: begin
                    fc_q       <= fc_q + 1'b1;
                    addrSh_q   <= addrSh_q << 1;
                    dataSh_q   <= dataSh_q << 1;
                    addr_sdo_q <= (fc_q < FC_ADDR_LAST) ? addrSh_q[ADDR_W-2] : 1'b0;
                    data_sdo_q <= (write_q && (fc_q < FC_DATA_LAST)) ? dataSh_q[DATA_W-2] : 1'b0;
                    if (fc_q == FC_ADDR_LAST) begin
                        state_q <= COMMIT;
                    end
                end

                COMMIT: begin
                    addr_sdo_q <= 1'b0;
                    data_sdo_q <= 1'b0;
                    if (fc_q == FC_LAST) begin
                        rws_q <= 3'b000;
                        if (write_q) begin
                            state_q     <= IDLE;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                            dc_q    <= '0;
                            rxSh_q  <= '0;
                        end
                    end else begin
                        fc_q <= fc_q + 1'b1;
`ifdef MRAM_HOST_B2B_EN
                        // Open the accept window on the last write cycle.
                        if (write_q && (fc_q == FC_PRE_LAST)) begin
                            cmd_ready_q <= 1'b1;
                        end
`endif
                    end
                end

                DRAIN: begin
                    dc_q <= dc_q + 1'b1;
                    if (dc_q >= DC_FIRST) begin
                        rxSh_q <= {rxSh_q[DATA_W-3:0], rdata_sdi};
                    end
                    if (dc_q == dcLast) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rspWord_d;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Command acceptance. A nop is consumed without driving a frame.
            if (handshake) begin
                write_q  <= cmd_write;
                bytes_q  <= cmd_bytes;
                addrSh_q <= cmd_addr[ADDR_W-2:0];
                dataSh_q <= cmd_wdata[DATA_W-2:0];
                fc_q     <= '0;
                if (cmd_bytes != 2'b00) begin
                    state_q     <= SHIFT;
                    cmd_ready_q <= 1'b0;
                    rws_q       <= {cmd_bytes, cmd_write};
                    addr_sdo_q  <= cmd_addr[ADDR_W-1];
                    data_sdo_q  <= cmd_write & cmd_wdata[DATA_W-1];
                end else begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rws_q       <= 3'b000;
                    addr_sdo_q  <= 1'b0;
                    data_sdo_q  <= 1'b0;
                end
            end
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign read_write_sel = rws_q;
    assign addr_sdo       = addr_sdo_q;
    assign data_sdo       = data_sdo_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign busy           = (state_q != IDLE);

endmodule
